// File: rtl/carry_skip_pkg.sv
// Shared defaults and derived pipeline depth for the pipelined carry-skip adder.
package carry_skip_pkg;

  localparam int WIDTH_DEF        = 64;
  localparam int BLOCK_DEF        = 4;
  localparam int STAGE_BLOCKS_DEF = 4;

  function automatic int calc_nstages(input int width, input int block, input int stage_blocks);
    return width / (block * stage_blocks);
  endfunction

endpackage

// File: rtl/carry_skip_block.sv
// One combinational carry-skip block: ripple carry inside, bypass mux when every bit propagates.
module carry_skip_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout
);

  logic [BLOCK-1:0] prop;
  logic [BLOCK-1:0] gen;
  logic [BLOCK:0]   carry;

  assign prop = a ^ b;
  assign gen  = a & b;

  always_comb begin
    carry[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
  end

  assign sum  = prop ^ carry[BLOCK-1:0];
  // Fully propagating block: incoming carry passes straight through, same value as the ripple.
  assign cout = (&prop) ? cin : carry[BLOCK];

endmodule

// File: rtl/carry_skip_adder_pipe.sv
// Pipelined add/subtract unit; each stage resolves STAGE_BLOCKS skip blocks and forwards only unconsumed operand bits.
module carry_skip_adder_pipe
  import carry_skip_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int BLOCK        = BLOCK_DEF,
  parameter int STAGE_BLOCKS = STAGE_BLOCKS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW      = BLOCK * STAGE_BLOCKS;
  localparam int NSTAGES = calc_nstages(WIDTH, BLOCK, STAGE_BLOCKS);

  if ((WIDTH % SW) != 0 || NSTAGES < 1) begin : g_bad_cfg
    $error("carry_skip_adder_pipe: WIDTH must be a non-zero multiple of BLOCK*STAGE_BLOCKS");
  end

  logic               advance;
  logic               accept;
  logic [WIDTH-1:0]   b_eff;
  logic               c_eff;
  logic [NSTAGES-1:0] valid_q;
  logic [NSTAGES-1:0] carry_q;
  logic [NSTAGES-1:0] stage_cout;

  assign advance   = !valid_q[NSTAGES-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_q[NSTAGES-1];
  assign accept    = in_valid && advance;
  assign b_eff     = sub ? ~b : b;
  assign c_eff     = sub ? 1'b1 : cin;

  // Valid and inter-stage carries shift together; the whole pipe freezes on a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
    end else if (advance) begin
      valid_q <= NSTAGES'({valid_q, accept});
      carry_q <= stage_cout;
    end
  end

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stg
    localparam int LO  = k * SW;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]        op_a;
    logic [REM-1:0]        op_b;
    logic                  cin_s;
    logic [SW-1:0]         slice;
    logic [STAGE_BLOCKS:0] chain;
    logic [LO+SW-1:0]      sum_q;

    if (k == 0) begin : g_first
      assign op_a  = a;
      assign op_b  = b_eff;
      assign cin_s = c_eff;
      always_ff @(posedge clk) begin
        if (rst)          sum_q <= '0;
        else if (advance) sum_q <= slice;
      end
    end else begin : g_next
      assign op_a  = g_stg[k-1].g_up.a_q;
      assign op_b  = g_stg[k-1].g_up.b_q;
      assign cin_s = carry_q[k-1];
      always_ff @(posedge clk) begin
        if (rst)          sum_q <= '0;
        else if (advance) sum_q <= {slice, g_stg[k-1].sum_q};
      end
    end

    assign chain[0]      = cin_s;
    assign stage_cout[k] = chain[STAGE_BLOCKS];

    for (genvar j = 0; j < STAGE_BLOCKS; j++) begin : g_blk
      carry_skip_block #(.BLOCK(BLOCK)) u_blk (
        .a    (op_a[j*BLOCK +: BLOCK]),
        .b    (op_b[j*BLOCK +: BLOCK]),
        .cin  (chain[j]),
        .sum  (slice[j*BLOCK +: BLOCK]),
        .cout (chain[j+1])
      );
    end

    if (k < NSTAGES - 1) begin : g_up
      logic [REM-SW-1:0] a_q;
      logic [REM-SW-1:0] b_q;
      always_ff @(posedge clk) begin
        if (advance) begin
          a_q <= op_a[REM-1:SW];
          b_q <= op_b[REM-1:SW];
        end
      end
    end

    if (k == NSTAGES - 1) begin : g_last
      logic ovf_q;
      // Top slice still holds the operand sign bits, so overflow is resolved here.
      always_ff @(posedge clk) begin
        if (rst)          ovf_q <= 1'b0;
        else if (advance) ovf_q <= (op_a[SW-1] == op_b[SW-1]) && (slice[SW-1] != op_a[SW-1]);
      end
    end
  end

  assign sum  = g_stg[NSTAGES-1].sum_q;
  assign cout = carry_q[NSTAGES-1];
  assign ovf  = g_stg[NSTAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_carry_skip_adder_pipe.sv
// Self-checking bench: directed corner cases, stalls, reset flush and a long randomized stream.
module tb_carry_skip_adder_pipe;

  localparam int W = 64;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  carry_skip_adder_pipe #(.WIDTH(64), .BLOCK(4), .STAGE_BLOCKS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Reference: unsigned sum for value/carry, wide signed sum range test for overflow.
  function automatic res_t ref_model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                     input logic ci, input logic sb);
    res_t r;
    logic [W:0] u;
    logic signed [W+1:0] s;
    logic [W-1:0] be;
    logic c;
    be = sb ? ~bv : bv;
    c  = sb ? 1'b1 : ci;
    u  = {1'b0, av} + {1'b0, be} + {{W{1'b0}}, c};
    s  = $signed({av[W-1], av[W-1], av}) + $signed({be[W-1], be[W-1], be})
       + $signed({{(W+1){1'b0}}, c});
    r.sum  = u[W-1:0];
    r.cout = u[W];
    r.ovf  = (s > 66'sd9223372036854775807) || (s < -66'sd9223372036854775808);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd64();
    logic [W-1:0] v;
    v = {$urandom, $urandom};
    return v;
  endfunction

  // Scoreboard: record accepted operands, compare every delivered result in order.
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        n_out++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result got sum=%h cout=%b ovf=%b required no result", sum, cout, ovf);
        end else begin
          e = exp_q.pop_front();
          if ({sum, cout, ovf} !== e) begin
            errors++;
            $display("FAIL result got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                     sum, cout, ovf, e.sum, e.cout, e.ovf);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(a, b, cin, sub));
    end
  end

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = rnd64(); b = rnd64(); cin = 1'b1; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL rst_sum got %h required 0", sum); end
    checks++; if (cout !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL rst_flags got cout=%b ovf=%b required 0 0", cout, ovf); end
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b required 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_release_valid got %b required 0", out_valid); end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [3];
    logic [W-1:0] tb [3];
    logic         tc [3];
    logic         ts [3];
    logic [W-1:0] es [3];
    logic         ec [3];
    logic         eo [3];
    int lat;
    ta = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'h7FFF_FFFF_FFFF_FFFF};
    tb = '{64'd0, 64'd7, 64'd1};
    tc = '{1'b1, 1'b1, 1'b0};
    ts = '{1'b0, 1'b1, 1'b0};
    es = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000};
    ec = '{1'b1, 1'b0, 1'b0};
    eo = '{1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = ta[i]; b = tb[i]; cin = tc[i]; sub = ts[i];
      @(posedge clk); #1;
      in_valid = 1'b0; a = rnd64(); b = rnd64(); cin = 1'b0; sub = 1'b1;
      lat = 1;
      while (!out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++; if (lat != 4) begin errors++; $display("FAIL dir%0d_latency got %0d required 4", i, lat); end
      checks++; if (sum !== es[i]) begin errors++; $display("FAIL dir%0d_sum got %h required %h", i, sum, es[i]); end
      checks++; if (cout !== ec[i]) begin errors++; $display("FAIL dir%0d_cout got %b required %b", i, cout, ec[i]); end
      checks++; if (ovf !== eo[i]) begin errors++; $display("FAIL dir%0d_ovf got %b required %b", i, ovf, eo[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int last  = -1;
    int nval  = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      in_valid = (c < 20);
      a = rnd64(); b = rnd64(); cin = 1'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
      if (out_valid) begin
        if (first < 0) first = c;
        last = c;
        nval++;
      end
    end
    in_valid = 1'b0;
    checks++; if (first != 3) begin errors++; $display("FAIL b2b_first got %0d required 3", first); end
    checks++; if (nval != 20 || last - first + 1 != 20) begin
      errors++; $display("FAIL b2b_throughput got %0d results over %0d cycles required 20 over 20", nval, last - first + 1);
    end
  endtask

  task automatic test_backpressure();
    int sent  = 0;
    int start = n_out;
    logic acc;
    logic [W-1:0] held;
    held = '0;
    for (int c = 0; c < 60; c++) begin
      in_valid = (sent < 10);
      a = rnd64(); b = rnd64(); cin = 1'($urandom); sub = 1'($urandom);
      out_ready = !(c >= 6 && c <= 8);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (c == 6) held = sum;
      if (c >= 6 && c <= 8) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++; $display("FAIL bp_stall c=%0d got in_ready=%b out_valid=%b required 0 1", c, in_ready, out_valid);
        end
      end
      if (c == 7 || c == 8) begin
        checks++;
        if (sum !== held) begin errors++; $display("FAIL bp_hold c=%0d got %h required %h", c, sum, held); end
      end
      @(posedge clk); #1;
      if (acc) sent++;
      if (sent == 10 && n_out - start == 10) break;
    end
    out_ready = 1'b1; in_valid = 1'b0;
    checks++;
    if (sent != 10 || n_out - start != 10) begin
      errors++; $display("FAIL bp_count got sent=%0d out=%0d required 10 10", sent, n_out - start);
    end
  endtask

  task automatic test_reset_midflight();
    res_t e;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = rnd64(); b = rnd64(); cin = 1'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b1; in_valid = 1'b1; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL mid_rst_outputs got sum=%h cout=%b ovf=%b required 0 0 0", sum, cout, ovf);
    end
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_flush c=%0d got %b required 0", c, out_valid); end
      @(posedge clk); #1;
    end
    in_valid = 1'b1; a = 64'h0123_4567_89AB_CDEF; b = 64'hFEDC_BA98_7654_3210; cin = 1'b1; sub = 1'b0;
    e = ref_model(a, b, cin, sub);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat != 4) begin errors++; $display("FAIL mid_rst_latency got %0d required 4", lat); end
    checks++; if (sum !== e.sum) begin errors++; $display("FAIL mid_rst_sum got %h required %h", sum, e.sum); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int sent  = 0;
    int start = n_out;
    logic acc;
    for (int c = 0; c < 40000; c++) begin
      if (sent == 10000 && exp_q.size() == 0) break;
      in_valid = (sent < 10000) && ($urandom_range(3) != 0);
      a = rnd64(); b = rnd64(); cin = 1'($urandom); sub = 1'($urandom);
      if ($urandom_range(7) == 0) begin
        a = '1; b = {63'd0, 1'($urandom)};
      end
      out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (sent != 10000 || exp_q.size() != 0 || n_out - start != 10000) begin
      errors++; $display("FAIL rand_complete got sent=%0d out=%0d pending=%0d required 10000 10000 0",
                         sent, n_out - start, exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/carry_skip_adder_pipe.md
CARRY_SKIP_ADDER_PIPE -- requirements
Module: carry_skip_adder_pipe

Interface
REQ-001 Parameter WIDTH, default 64, operand and sum width in bits.
REQ-002 Parameter BLOCK, default 4, carry-skip block size in bits.
REQ-003 Parameter STAGE_BLOCKS, default 4, skip blocks evaluated per pipeline stage.
REQ-004 Derived constant NSTAGES = WIDTH/(BLOCK*STAGE_BLOCKS); WIDTH SHALL be an exact multiple of BLOCK*STAGE_BLOCKS, otherwise elaboration fails.
REQ-005 Port clk, input, 1, the single clock; all state on rising edge.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port in_valid, input, 1, operand set present.
REQ-008 Port in_ready, output, 1, block accepts operands this cycle.
REQ-009 Ports a and b, input, WIDTH, operands.
REQ-010 Port cin, input, 1, carry-in, used in add mode only.
REQ-011 Port sub, input, 1, 0 = add, 1 = subtract.
REQ-012 Port out_valid, output, 1, result present.
REQ-013 Port out_ready, input, 1, consumer accepts result.
REQ-014 Port sum, output, WIDTH, result.
REQ-015 Port cout, output, 1, carry out of bit WIDTH-1.
REQ-016 Port ovf, output, 1, two's-complement signed overflow.

Function
REQ-017 Add mode: {cout,sum} = a + b + cin; subtract mode: {cout,sum} = a + ~b + 1, with cin ignored.
REQ-018 ovf = (sign a == sign of effective b) && (sum sign != sign a), where effective b is b in add mode and ~b in subtract mode.
REQ-019 Stage k (0..NSTAGES-1) computes sum slice k via STAGE_BLOCKS chained skip blocks, using the carry registered by stage k-1 (stage 0 uses the effective carry-in).
REQ-020 Stage k registers: its own valid bit, the computed lower sum slices, carry out, and the still-unprocessed upper operand slices; it does not keep already-consumed operand bits.
REQ-021 Skip rule per block: carry_out = (all propagate bits P=a^b set) ? carry_in : ripple carry; the result must equal plain ripple addition.
REQ-022 Latency: a transaction accepted on edge n presents out_valid on the cycle after edge n+NSTAGES-1, i.e. NSTAGES cycles.
REQ-023 Global stall: advance = !out_valid || out_ready; when advance=1 every stage shifts one step, and when advance=0 all stages hold.
REQ-024 in_ready = advance; a transfer occurs when in_valid && in_ready; when advance=1 && !in_valid a bubble (valid=0) enters stage 0.
REQ-025 Throughput: one result per cycle with out_ready held high.
REQ-026 sum, cout and ovf remain stable while out_valid=1 && out_ready=0.
REQ-027 Values on a, b, cin and sub are don't-care when no transfer occurs; bubbles never produce out_valid.
REQ-028 Ordering: results emerge in acceptance order, with none dropped or duplicated under any out_ready pattern.

Reset
REQ-029 While rst=1: all stage valid bits = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0; in_ready = 1 from the first cycle after reset.
REQ-030 Reset mid-operation discards all in-flight transactions, and no partial result appears after reset release.
REQ-031 Reset takes priority over a simultaneous in_valid; the operand set presented in that cycle is not accepted.

Structure
REQ-032 Package carry_skip_pkg holds default WIDTH, BLOCK and STAGE_BLOCKS, plus a function computing NSTAGES.
REQ-033 Sub-module carry_skip_block (combinational, parameter BLOCK) is instantiated NSTAGES*STAGE_BLOCKS times via generate, with pipeline registers in the top level only.

Verification (WIDTH=64, BLOCK=4, STAGE_BLOCKS=4, NSTAGES=4)
REQ-034 Full skip chain: a=FFFF_FFFF_FFFF_FFFF, b=0, cin=1, sub=0 -> 4 cycles later: sum=0, cout=1, ovf=0.
REQ-035 Subtract: a=5, b=7, sub=1, cin=1 (ignored) -> sum=FFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
REQ-036 Signed overflow: a=7FFF_FFFF_FFFF_FFFF, b=1, add, cin=0 -> sum=8000_0000_0000_0000, ovf=1, cout=0.
REQ-037 Backpressure: stream 10 random transactions and hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 while stalled, sum held stable, all 10 results correct and in order versus a reference model.
REQ-038 Reset mid-flight: accept 3 transactions, assert rst for 1 cycle on the next cycle -> out_valid stays 0 until a new transaction is accepted, and that transaction emerges 4 cycles later.
REQ-039 Random: 10k transactions with random in_valid/out_ready -> zero mismatches with the reference model and one result per cycle during unstalled bursts.
